// File: rtl/singleport_ram_be.sv
// singleport_ram_be
//   Parametrised single-port synchronous RAM with byte-enable writes, a
//   valid/ready request port and a one-cycle registered response. A built-in
//   clear engine writes CLR_VAL to every word after reset and whenever
//   clear_req is pulsed while idle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   clear_req  1-cycle pulse that starts a clear sweep (only honoured when idle)
//   busy       high while the clear engine runs
//   req_valid  request present
//   req_ready  request accepted when req_valid & req_ready
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_be     byte enables, bit i covers bits [8i+7:8i]
//   rsp_valid  1-cycle pulse one cycle after each accepted request
//   rsp_rdata  response data, held until the next response
//
// READ_MODE selects the data returned for a write: 0 = pre-write word,
// 1 = merged post-write word.

module singleport_ram_be #(
    parameter int                DATA_W    = 128,
    parameter int                ADDR_W    = 3,
    parameter bit                READ_MODE = 1'b0,
    parameter logic [DATA_W-1:0] CLR_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata
);

    localparam int                BE_W      = DATA_W / 8;
    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_addr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept_p0;
    logic [DATA_W-1:0]   old_word_p0;
    logic [DATA_W-1:0]   merged_p0;

    logic                vld_p1;
    logic [DATA_W-1:0]   rdata_p1;

    // Replace the enabled bytes of the stored word with the write data.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] wdata,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Stage p0: request decode, array read and byte merge.
    // clear_req takes priority over a same-cycle request, so it masks ready.
    assign busy        = (state == CLEAR);
    assign req_ready   = (state == READY) && !clear_req;
    assign accept_p0   = req_valid && req_ready;
    assign old_word_p0 = mem[req_addr];
    assign merged_p0   = byte_merge(old_word_p0, req_wdata, req_be);

    // Storage update. The sweep and request writes are mutually exclusive
    // because requests are only accepted in READY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_addr] <= CLR_VAL;
            end else if (accept_p0 && req_we) begin
                mem[req_addr] <= merged_p0;
            end
        end
    end

    // Clear engine. The sweep ends on the terminal address rather than on
    // counter wrap, so it always takes exactly DEPTH cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state    <= READY;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                READY: begin
                    if (clear_req) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                default: begin
                    state    <= CLEAR;
                    clr_addr <= '0;
                end
            endcase
        end
    end

    // Stage p1: registered response. The response data is captured from the
    // array at acceptance, so a sweep starting right after cannot affect it.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                rdata_p1 <= (req_we && READ_MODE) ? merged_p0 : old_word_p0;
            end
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_rdata = rdata_p1;

endmodule

// File: tb/tb_singleport_ram_be.sv
// Bench for singleport_ram_be: two instances (READ_MODE 0 and 1) share the same
// stimulus; each has its own expected-response queue popped by its own monitor.

module tb_singleport_ram_be;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 3;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear_req;
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;

    logic              busy0, busy1;
    logic              req_ready0, req_ready1;
    logic              rsp_valid0, rsp_valid1;
    logic [DATA_W-1:0] rsp_rdata0, rsp_rdata1;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];

    localparam logic [DATA_W-1:0] ALL_A5 = {16{8'hA5}};
    localparam logic [DATA_W-1:0] ALL_11 = {16{8'h11}};
    localparam logic [DATA_W-1:0] ALL_FF = {16{8'hFF}};
    localparam logic [DATA_W-1:0] MASKED = {64'h1111111111111111, 32'hFFFFFFFF, 32'h11111111};
    localparam logic [DATA_W-1:0] ONE    = 128'h1;
    localparam logic [DATA_W-1:0] TWO    = 128'h2;
    localparam logic [DATA_W-1:0] ZERO   = '0;

    always #5 clk = ~clk;

    singleport_ram_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_MODE(1'b0), .CLR_VAL('0)) dut0 (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy0),
        .req_valid(req_valid), .req_ready(req_ready0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0)
    );

    singleport_ram_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_MODE(1'b1), .CLR_VAL('0)) dut1 (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy1),
        .req_valid(req_valid), .req_ready(req_ready1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1)
    );

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitors: every response pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rsp_valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp0_unexpected: got %h, expected no response", rsp_rdata0);
            end else begin
                chk("rsp0_data", rsp_rdata0, q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp1_unexpected: got %h, expected no response", rsp_rdata1);
            end else begin
                chk("rsp1_data", rsp_rdata1, q1.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with req_valid low.
    task automatic req(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [BE_W-1:0] be, input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        #1;
        chk("req_ready", {127'b0, req_ready0}, 128'h1);
        if (req_ready0) q0.push_back(e0);
        if (req_ready1) q1.push_back(e1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Counts busy cycles of a running sweep (bounded); optionally pulses
    // clear_req at iteration clr_at. Returns at posedge+1.
    task automatic sweep(input string name, input int clr_at);
        int n;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy0) break;
            n++;
            clear_req = (i == clr_at);
        end
        clear_req = 1'b0;
        chk(name, n, 8);
        chk({name, "_ready"}, {127'b0, req_ready0}, 128'h1);
        chk({name, "_busy1"}, {127'b0, busy1}, 128'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        clear_req = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", {127'b0, busy0}, 128'h1);
        chk("rst_ready", {127'b0, req_ready0}, 128'h0);
        chk("rst_rsp_valid", {127'b0, rsp_valid0}, 128'h0);
        chk("rst_rsp_rdata", rsp_rdata0, ZERO);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sweep("init_sweep", -1);

        // All words cleared, read back-to-back
        for (int i = 0; i < 8; i++) req(1'b0, ADDR_W'(i), ZERO, '0, ZERO, ZERO);

        // Full write then read
        req(1'b1, 3'd5, ALL_A5, '1, ZERO, ALL_A5);
        req(1'b0, 3'd5, ZERO, '0, ALL_A5, ALL_A5);

        // Byte mask
        req(1'b1, 3'd2, ALL_11, '1, ZERO, ALL_11);
        req(1'b1, 3'd2, ALL_FF, 16'h00F0, ALL_11, MASKED);
        req(1'b0, 3'd2, ZERO, '0, MASKED, MASKED);

        // Read-first vs write-first, then zero byte-enable write
        req(1'b1, 3'd3, ONE, '1, ZERO, ONE);
        req(1'b1, 3'd3, TWO, '1, ONE, TWO);
        req(1'b1, 3'd3, ALL_FF, '0, TWO, TWO);
        req(1'b0, 3'd3, ZERO, '0, TWO, TWO);

        // Read accepted just before clear_req; clear_req with a request blocks it
        req(1'b0, 3'd5, ZERO, '0, ALL_A5, ALL_A5);
        clear_req = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 3'd2;
        #1;
        chk("clr_blocks_ready", {127'b0, req_ready0}, 128'h0);
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        req_valid = 1'b0;
        sweep("clr_sweep", 2);
        for (int i = 0; i < 8; i++) req(1'b0, ADDR_W'(i), ZERO, '0, ZERO, ZERO);

        // Reset together with a presented request: no response, data reset
        req(1'b1, 3'd1, ALL_A5, '1, ZERO, ALL_A5);
        req(1'b0, 3'd1, ZERO, '0, ALL_A5, ALL_A5);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 3'd1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        chk("rstreq_rsp_valid", {127'b0, rsp_valid0}, 128'h0);
        chk("rstreq_rdata0", rsp_rdata0, ZERO);
        chk("rstreq_rdata1", rsp_rdata1, ZERO);
        sweep("rstreq_sweep", -1);

        // Reset at sweep cycle 4 restarts a full sweep
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sweep("rst_mid_sweep", -1);
        req(1'b0, 3'd1, ZERO, '0, ZERO, ZERO);

        repeat (3) @(posedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
